// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: shares a 1RW1R SRAM macro between requesters A and B, clearing the array after reset.
// Ports: clk/rst (sync, active high); a_*/b_* valid/ready request channels with fixed 2-cycle read responses
// (rvalid/rdata); init_done after the clear sweep; sram_* registered macro pins (port0 RW, port1 R).
// Build option: define SRAM_ARB_FWD_EN to forward write data to a same-address read issued in the same cycle.
module sram_1rw1r_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
`ifdef SRAM_ARB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif
  logic [0:0] state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic rr;
  logic init, aw, ar, bw, br, same, ga, gb;
  logic fwd_a, fwd_b, p0_a, p0_b, p1_a, p1_b;
  logic t0_v1, t0_o1, t0_v2, t0_o2;
  logic t1_v1, t1_o1, t1_f1, t1_v2, t1_o2, t1_f2;
  logic [DATA_WIDTH-1:0] t1_d1, t1_d2, d1;
  // rr: 0 = A has priority, 1 = B has priority; only a write/write clash consumes it
  always_comb begin
    init = state == S_INIT;
    aw = a_valid & a_we;
    ar = a_valid & ~a_we;
    bw = b_valid & b_we;
    br = b_valid & ~b_we;
    same = a_addr == b_addr;
    ga = (aw & bw) ? ~rr : (ar & bw) ? (~same | FWD) : a_valid;
    gb = (aw & bw) ? rr : (aw & br) ? (~same | FWD) : b_valid;
    a_ready = ~init & ga;
    b_ready = ~init & gb;
    fwd_a = FWD & a_ready & ar & bw & same;
    fwd_b = FWD & b_ready & br & aw & same;
    // on a read/read pair the non-priority reader borrows port0
    p0_a = a_ready & (a_we | (br & rr));
    p0_b = b_ready & (b_we | (ar & ~rr));
    p1_a = a_ready & ~a_we & ~p0_a & ~fwd_a;
    p1_b = b_ready & ~b_we & ~p0_b & ~fwd_b;
    d1 = t1_f2 ? t1_d2 : sram_dout1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt <= '0;
      rr <= 1'b0;
      init_done <= 1'b0;
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
      sram_addr0 <= '0;
      sram_din0 <= '0;
      sram_csb1 <= 1'b1;
      sram_addr1 <= '0;
      {t0_v1, t0_o1, t0_v2, t0_o2} <= '0;
      {t1_v1, t1_o1, t1_f1, t1_v2, t1_o2, t1_f2} <= '0;
      t1_d1 <= '0;
      t1_d2 <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (init) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= S_RUN;
          init_done <= 1'b1;
        end
      end
      if (aw & bw & ~init) rr <= ~rr;
      sram_csb0 <= ~(init | p0_a | p0_b);
      sram_web0 <= ~(init | (p0_a & a_we) | (p0_b & b_we));
      sram_addr0 <= init ? cnt : p0_a ? a_addr : p0_b ? b_addr : sram_addr0;
      sram_din0 <= init ? INIT_VALUE : (p0_a & a_we) ? a_wdata : (p0_b & b_we) ? b_wdata : sram_din0;
      sram_csb1 <= ~(p1_a | p1_b);
      sram_addr1 <= p1_a ? a_addr : p1_b ? b_addr : sram_addr1;
      t0_v1 <= (p0_a & ~a_we) | (p0_b & ~b_we);
      t0_o1 <= p0_b;
      t0_v2 <= t0_v1;
      t0_o2 <= t0_o1;
      t1_v1 <= p1_a | p1_b | fwd_a | fwd_b;
      t1_o1 <= p1_b | fwd_b;
      t1_f1 <= fwd_a | fwd_b;
      t1_d1 <= fwd_a ? b_wdata : a_wdata;
      t1_v2 <= t1_v1;
      t1_o2 <= t1_o1;
      t1_f2 <= t1_f1;
      t1_d2 <= t1_d1;
      a_rvalid <= (t0_v2 & ~t0_o2) | (t1_v2 & ~t1_o2);
      b_rvalid <= (t0_v2 & t0_o2) | (t1_v2 & t1_o2);
      a_rdata <= (t0_v2 & ~t0_o2) ? sram_dout0 : (t1_v2 & ~t1_o2) ? d1 : a_rdata;
      b_rdata <= (t0_v2 & t0_o2) ? sram_dout0 : (t1_v2 & t1_o2) ? d1 : b_rdata;
    end
  end
endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// tb_sram_1rw1r_arbiter: directed self-checking bench with a behavioural 1RW1R SRAM attached.
module tb_sram_1rw1r_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready, a_we, a_rvalid;
  logic [5:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic b_valid, b_ready, b_we, b_rvalid;
  logic [5:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic init_done, sram_csb0, sram_web0, sram_csb1;
  logic [5:0] sram_addr0, sram_addr1;
  logic [7:0] sram_din0, sram_dout0, sram_dout1;
  logic [7:0] mem [64];
  int checks = 0;
  int failures = 0;
  int n;
  logic saw;
  always #5 clk = ~clk;
  sram_1rw1r_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else sram_dout0 <= mem[sram_addr0];
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    tick;
    chk("rst_csb0", 32'(sram_csb0), 1);
    chk("rst_web0", 32'(sram_web0), 1);
    chk("rst_csb1", 32'(sram_csb1), 1);
    chk("rst_addr0", 32'(sram_addr0), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rdata", 32'(b_rdata), 0);
    rst = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd5;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (i == 63) a_valid = 1'b0;
      #1;
      chk("init_addr0", 32'(sram_addr0), 32'(i));
      chk("init_csb0", 32'(sram_csb0), 0);
      chk("init_web0", 32'(sram_web0), 0);
      chk("init_din0", 32'(sram_din0), 0);
      chk("init_done_edge", 32'(init_done), 32'(i == 63));
      if (i < 63) chk("init_a_ready", 32'(a_ready), 0);
    end
    tick;
    chk("idle_csb0", 32'(sram_csb0), 1);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd5;
    #1;
    chk("rd5_a_ready", 32'(a_ready), 1);
    chk("rd5_b_ready", 32'(b_ready), 0);
    tick;
    a_valid = 1'b0;
    chk("rd5_csb1", 32'(sram_csb1), 0);
    chk("rd5_addr1", 32'(sram_addr1), 5);
    chk("rd5_csb0", 32'(sram_csb0), 1);
    tick;
    chk("rd5_early", 32'(a_rvalid), 0);
    tick;
    chk("rd5_rvalid", 32'(a_rvalid), 1);
    chk("rd5_rdata", 32'(a_rdata), 0);
    tick;
    chk("rd5_rvalid_drop", 32'(a_rvalid), 0);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd10; a_wdata = 8'h3C;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 6'd11; b_wdata = 8'hA5;
    #1;
    chk("ww1_a_ready", 32'(a_ready), 1);
    chk("ww1_b_ready", 32'(b_ready), 0);
    tick;
    a_valid = 1'b0;
    #1;
    chk("ww1_addr0", 32'(sram_addr0), 10);
    chk("ww1_din0", 32'(sram_din0), 'h3C);
    chk("ww1_web0", 32'(sram_web0), 0);
    chk("ww1_b_retry", 32'(b_ready), 1);
    tick;
    b_valid = 1'b0;
    chk("ww1_addr0_b", 32'(sram_addr0), 11);
    chk("ww1_din0_b", 32'(sram_din0), 'hA5);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd10;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 6'd11;
    #1;
    chk("rr_a_ready", 32'(a_ready), 1);
    chk("rr_b_ready", 32'(b_ready), 1);
    tick;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rr_csb0", 32'(sram_csb0), 0);
    chk("rr_web0", 32'(sram_web0), 1);
    chk("rr_addr0", 32'(sram_addr0), 10);
    chk("rr_csb1", 32'(sram_csb1), 0);
    chk("rr_addr1", 32'(sram_addr1), 11);
    tick;
    tick;
    chk("rr_a_rvalid", 32'(a_rvalid), 1);
    chk("rr_a_rdata", 32'(a_rdata), 'h3C);
    chk("rr_b_rvalid", 32'(b_rvalid), 1);
    chk("rr_b_rdata", 32'(b_rdata), 'hA5);
    tick;
    chk("rr_a_drop", 32'(a_rvalid), 0);
    chk("rr_a_hold", 32'(a_rdata), 'h3C);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd30; a_wdata = 8'h11;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 6'd31; b_wdata = 8'h22;
    #1;
    chk("ww2_a_ready", 32'(a_ready), 0);
    chk("ww2_b_ready", 32'(b_ready), 1);
    tick;
    b_valid = 1'b0;
    #1;
    chk("ww2_addr0", 32'(sram_addr0), 31);
    chk("ww2_din0", 32'(sram_din0), 'h22);
    chk("ww2_a_retry", 32'(a_ready), 1);
    tick;
    a_valid = 1'b0;
    chk("ww2_addr0_a", 32'(sram_addr0), 30);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 6'd20; a_wdata = 8'h77;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 6'd20;
    #1;
    chk("col_a_ready", 32'(a_ready), 1);
`ifdef SRAM_ARB_FWD_EN
    chk("col_b_ready", 32'(b_ready), 1);
    tick;
    a_valid = 1'b0; b_valid = 1'b0;
    chk("col_addr0", 32'(sram_addr0), 20);
    chk("col_din0", 32'(sram_din0), 'h77);
    chk("col_csb1", 32'(sram_csb1), 1);
    tick;
    chk("col_early", 32'(b_rvalid), 0);
    tick;
`else
    chk("col_b_ready", 32'(b_ready), 0);
    tick;
    a_valid = 1'b0;
    #1;
    chk("col_addr0", 32'(sram_addr0), 20);
    chk("col_din0", 32'(sram_din0), 'h77);
    chk("col_csb1", 32'(sram_csb1), 1);
    chk("col_b_retry", 32'(b_ready), 1);
    tick;
    b_valid = 1'b0;
    chk("col_csb1_rd", 32'(sram_csb1), 0);
    chk("col_addr1", 32'(sram_addr1), 20);
    tick;
    tick;
`endif
    chk("col_b_rvalid", 32'(b_rvalid), 1);
    chk("col_b_rdata", 32'(b_rdata), 'h77);
    tick;
    chk("col_b_drop", 32'(b_rvalid), 0);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd20;
    #1;
    chk("mid_a_ready", 32'(a_ready), 1);
    tick;
    a_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("mid_rvalid", 32'(a_rvalid), 0);
    chk("mid_csb0", 32'(sram_csb0), 1);
    chk("mid_csb1", 32'(sram_csb1), 1);
    chk("mid_web0", 32'(sram_web0), 1);
    chk("mid_init_done", 32'(init_done), 0);
    rst = 1'b0;
    n = 0;
    saw = 1'b0;
    while (!init_done && n < 200) begin
      tick;
      n++;
      if (a_rvalid) saw = 1'b1;
    end
    chk("resweep_cycles", 32'(n), 64);
    chk("resweep_no_rvalid", 32'(saw), 0);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 6'd20;
    #1;
    chk("reread_ready", 32'(a_ready), 1);
    tick;
    a_valid = 1'b0;
    tick;
    tick;
    chk("reread_rvalid", 32'(a_rvalid), 1);
    chk("reread_rdata", 32'(a_rdata), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
